// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl -- N x N tic-tac-toe game controller.
//
// Tracks a one-hot cursor, the X and O occupancy masks, whose turn it is and
// the game state (PLAY -> CHECK -> PLAY/WIN/DRAW). A placement is accepted
// only on an empty cell. The move is judged during a single CHECK cycle, so
// the result shows on game_state two cycles after the accepting enter.
//
// Configuration macro:
//   TTT_WRAP_EN  defined   : cursor moves past an edge wrap to the opposite
//                            edge of the same row/column.
//                undefined : cursor moves past an edge are ignored (clamp).
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high reset
//   w, s, a, d   in   cursor up / down / left / right (level-sampled)
//   enter        in   place mark, or start a new game after WIN/DRAW
//   cursor_pos   out  one-hot cursor cell, index = row*N + col
//   board_x      out  cells held by X
//   board_o      out  cells held by O
//   turn         out  player to move (0 = X, 1 = O)
//   game_state   out  00 PLAY, 01 CHECK, 10 WIN, 11 DRAW
//   winner       out  winning player in WIN, 0 otherwise
//   move_count   out  number of marks placed
//   illegal      out  one-cycle pulse when enter hits an occupied cell
//   draw_trigger out  one-cycle redraw request after any visible change
module ttt_game_ctrl #(
  parameter int N = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         w,
  input  logic                         s,
  input  logic                         a,
  input  logic                         d,
  input  logic                         enter,
  output logic [N*N-1:0]               cursor_pos,
  output logic [N*N-1:0]               board_x,
  output logic [N*N-1:0]               board_o,
  output logic                         turn,
  output logic [1:0]                   game_state,
  output logic                         winner,
  output logic [$clog2(N*N+1)-1:0]     move_count,
  output logic                         illegal,
  output logic                         draw_trigger
);

  localparam int CELLS = N * N;
  localparam int RW    = $clog2(N);
  localparam int MCW   = $clog2(N * N + 1);
  localparam logic [RW-1:0] LAST = RW'(N - 1);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'b00,
    ST_CHECK = 2'b01,
    ST_WIN   = 2'b10,
    ST_DRAW  = 2'b11
  } state_t;

  state_t            state_q, state_n;
  logic [RW-1:0]     row_q, col_q, row_n, col_n;
  logic [CELLS-1:0]  cursor_n, bx_n, bo_n;
  logic              turn_n, winner_n, illegal_n, changed;
  logic [MCW-1:0]    mc_n;

  // Step towards row/col 0; at the edge either wrap or hold.
  function automatic logic [RW-1:0] step_dec(input logic [RW-1:0] v);
`ifdef TTT_WRAP_EN
    return (v == '0) ? LAST : v - 1'b1;
`else
    return (v == '0) ? v : v - 1'b1;
`endif
  endfunction

  // Step towards row/col N-1; at the edge either wrap or hold.
  function automatic logic [RW-1:0] step_inc(input logic [RW-1:0] v);
`ifdef TTT_WRAP_EN
    return (v == LAST) ? '0 : v + 1'b1;
`else
    return (v == LAST) ? v : v + 1'b1;
`endif
  endfunction

  function automatic logic [CELLS-1:0] onehot(input logic [RW-1:0] r,
                                              input logic [RW-1:0] c);
    logic [CELLS-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        v[i*N+j] = (r == RW'(i)) && (c == RW'(j));
      end
    end
    return v;
  endfunction

  // True when the mask holds any complete row, column or diagonal.
  function automatic logic has_line(input logic [CELLS-1:0] b);
    logic hit, r_all, c_all, d_all, a_all;
    hit   = 1'b0;
    d_all = 1'b1;
    a_all = 1'b1;
    for (int i = 0; i < N; i++) begin
      r_all = 1'b1;
      c_all = 1'b1;
      for (int j = 0; j < N; j++) begin
        r_all = r_all & b[i*N+j];
        c_all = c_all & b[j*N+i];
      end
      hit   = hit | r_all | c_all;
      d_all = d_all & b[i*N+i];
      a_all = a_all & b[i*N+(N-1-i)];
    end
    return hit | d_all | a_all;
  endfunction

  always_comb begin
    state_n   = state_q;
    row_n     = row_q;
    col_n     = col_q;
    bx_n      = board_x;
    bo_n      = board_o;
    turn_n    = turn;
    winner_n  = winner;
    mc_n      = move_count;
    illegal_n = 1'b0;

    case (state_q)
      ST_PLAY: begin
        if (w)      row_n = step_dec(row_q);
        else if (s) row_n = step_inc(row_q);
        else if (a) col_n = step_dec(col_q);
        else if (d) col_n = step_inc(col_q);

        // Placement uses the cursor as it stood before this cycle's move.
        if (enter) begin
          if (|(cursor_pos & (board_x | board_o))) begin
            illegal_n = 1'b1;
          end else begin
            if (turn) bo_n = board_o | cursor_pos;
            else      bx_n = board_x | cursor_pos;
            mc_n    = move_count + 1'b1;
            state_n = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        // A line on the final mark beats a full board.
        if (has_line(turn ? board_o : board_x)) begin
          state_n  = ST_WIN;
          winner_n = turn;
        end else if (move_count == MCW'(CELLS)) begin
          state_n = ST_DRAW;
        end else begin
          state_n = ST_PLAY;
          turn_n  = ~turn;
        end
      end

      default: begin
        if (enter) begin
          state_n  = ST_PLAY;
          row_n    = '0;
          col_n    = '0;
          bx_n     = '0;
          bo_n     = '0;
          turn_n   = 1'b0;
          winner_n = 1'b0;
          mc_n     = '0;
        end
      end
    endcase

    cursor_n = onehot(row_n, col_n);
    changed  = (cursor_n != cursor_pos) || (bx_n != board_x) ||
               (bo_n != board_o) || (state_n != state_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_PLAY;
      row_q        <= '0;
      col_q        <= '0;
      cursor_pos   <= CELLS'(1);
      board_x      <= '0;
      board_o      <= '0;
      turn         <= 1'b0;
      winner       <= 1'b0;
      move_count   <= '0;
      illegal      <= 1'b0;
      draw_trigger <= 1'b1;
    end else begin
      state_q      <= state_n;
      row_q        <= row_n;
      col_q        <= col_n;
      cursor_pos   <= cursor_n;
      board_x      <= bx_n;
      board_o      <= bo_n;
      turn         <= turn_n;
      winner       <= winner_n;
      move_count   <= mc_n;
      illegal      <= illegal_n;
      draw_trigger <= changed;
    end
  end

  assign game_state = state_q;

endmodule

// File: doc/ttt_game_ctrl.md
TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

Interface
REQ-001 SHALL have parameter N, default 3, meaning board dimension (N x N cells); legal range 3..8.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  meaning reset, which is synchronous and active-high.
REQ-004 SHALL have ports w, s, a, d  input  1 each  meaning cursor up, down, left and right requests, level-sampled each cycle.
REQ-005 SHALL have port enter  input  1  meaning place a mark at the cursor, or start a new game when the game is over.
REQ-006 SHALL have port cursor_pos  output  N*N  meaning one-hot cursor cell; cell index = row*N + col, with row 0 at the top and col 0 at the left.
REQ-007 SHALL have ports board_x, board_o  output  N*N each  meaning occupancy masks for player X and player O.
REQ-008 SHALL have port turn  output  1  meaning the player to move (0 = X, 1 = O).
REQ-009 SHALL have port game_state  output  2  meaning 00 PLAY, 01 CHECK, 10 WIN, 11 DRAW.
REQ-010 SHALL have port winner  output  1  meaning the winning player; valid only in WIN, 0 otherwise.
REQ-011 SHALL have port move_count  output  clog2(N*N+1)  meaning the number of marks placed.
REQ-012 SHALL have port illegal  output  1  meaning a one-cycle pulse when enter is rejected.
REQ-013 SHALL have port draw_trigger  output  1  meaning a one-cycle redraw request to the display.

Function
REQ-014 SHALL take cursor moves only in PLAY, with priority w > s > a > d, at most one move per cycle, registered at the next edge.
REQ-015 SHALL, with TTT_WRAP_EN undefined, ignore a move at an edge (w on row 0, s on row N-1, a on col 0, d on col N-1), so the cursor holds.
REQ-016 SHALL, in PLAY, accept enter when the cursor cell is clear in both board_x and board_o.
- The cell is set in board_<turn>; move_count increments; state goes to CHECK.
REQ-017 SHALL, in PLAY, reject enter on an occupied cell: boards unchanged, illegal=1 for exactly one cycle, state stays PLAY.
REQ-018 SHALL, on the same cycle as enter, still apply any move; placement uses the pre-move cursor.
REQ-019 SHALL stay in CHECK for exactly one cycle, evaluating the board of the player who just moved.
- Any full row, full column, main diagonal or anti-diagonal (line length N) -> WIN, winner=turn, turn held.
- Otherwise, move_count == N*N -> DRAW.
- Otherwise -> PLAY, with turn toggled.
REQ-020 SHALL give WIN priority over DRAW when the final mark completes a line.
REQ-021 SHALL make the result visible on game_state exactly 2 cycles after the accepting enter edge.
REQ-022 SHALL, in WIN or DRAW, ignore w/s/a/d.
- enter starts a new game: boards clear, cursor_pos bit 0, turn=0, move_count=0, winner=0, state PLAY.
REQ-023 SHALL ignore enter received during CHECK.
REQ-024 SHALL pulse draw_trigger for one cycle on the cycle after any change of cursor_pos, board_x, board_o or game_state.
REQ-025 SHALL keep board_x & board_o == 0 at all times.

Reset
REQ-026 SHALL, while reset=1 at a clock edge, set cursor_pos to bit 0 only, board_x=0, board_o=0, turn=0, game_state=PLAY, winner=0, move_count=0, illegal=0, draw_trigger=1.
REQ-027 SHALL let reset override any simultaneous input or mid-game/CHECK state; draw_trigger returns to 0 on the first non-reset cycle without changes.

Configuration
REQ-028 SHALL, with macro TTT_WRAP_EN defined, wrap edge moves within the same column or row: w on row 0 -> row N-1, s on row N-1 -> row 0, a on col 0 -> col N-1, d on col N-1 -> col 0.
REQ-029 SHALL, without TTT_WRAP_EN, clamp at edges per REQ-015; all other behaviour is identical either way.

Verification (N=3)
REQ-030 SHALL cover the X win: X at cells 0,1,2 with O at 3,4 interleaved.
- Two cycles after the fifth accepted enter: game_state=10, winner=0, move_count=5.
REQ-031 SHALL cover the draw: fill X 0,2,3,7,5 and O 1,4,6,8 in alternation.
- Two cycles after the ninth accepted enter: game_state=11, move_count=9.
REQ-032 SHALL cover the illegal move: enter on cell 4 twice.
- Second enter: illegal pulse of 1 cycle; board_o unchanged; turn=1 still.
REQ-033 SHALL cover the edge: w pressed at cursor bit 0.
- Without TTT_WRAP_EN the cursor stays at bit 0.
- With TTT_WRAP_EN the cursor moves to bit 6.
REQ-034 SHALL cover enter+d together at cell 0.
- Mark placed at cell 0; cursor moves to bit 1; draw_trigger pulses the following cycle.
REQ-035 SHALL cover reset asserted during CHECK.
- Next cycle: all outputs at REQ-026 values; a following enter places X at cell 0.
